// File: rtl/usd_pkg.sv
// Shared definitions for the uSD APU bridge: default word geometry and the
// result-collection FSM state encoding.
package usd_pkg;

    localparam int CMD_W_DEF  = 72;
    localparam int RES_W_DEF  = 36;
    localparam int CH_LSB_DEF = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CAPT  = 2'd2,
        HOLD  = 2'd3
    } resState_e;

endpackage

// File: rtl/usd_rst_stretch.sv
// Soft-reset stretcher: brings the asynchronous APU reset strobe into apuClk
// with a 2-flop synchroniser, detects its rising edge, and runs one reload
// counter per channel. A channel's reset is high while its counter is non-zero,
// so a fresh edge during a pulse simply extends it.
module usd_rst_stretch #(
    parameter int WIDTH      = 2,
    parameter int RST_CYCLES = 15
) (
    input  logic             apuClk,
    input  logic             sysRstN,
    input  logic             apuReset,
    input  logic [WIDTH-1:0] apuResetMask,
    output logic [WIDTH-1:0] chRst
);

    logic       sync0;
    logic       sync1;
    logic       syncPrev;
    logic       resetEdge;
    logic [7:0] rstCnt [WIDTH];

    // Synchronise the strobe and keep one delayed copy for edge detection.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            syncPrev <= 1'b0;
        end else begin
            sync0    <= apuReset;
            sync1    <= sync0;
            syncPrev <= sync1;
        end
    end

    assign resetEdge = sync1 & ~syncPrev;

    // Per-channel counters: reload on a masked edge, otherwise count down to zero.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            for (int i = 0; i < WIDTH; i++) rstCnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (resetEdge && apuResetMask[i]) begin
                    rstCnt[i] <= 8'(RST_CYCLES);
                end else if (rstCnt[i] != 8'd0) begin
                    rstCnt[i] <= rstCnt[i] - 8'd1;
                end
            end
        end
    end

    // Reset is asserted for exactly as many cycles as the counter is non-zero.
    always_comb begin
        chRst = '0;
        for (int i = 0; i < WIDTH; i++) chRst[i] = (rstCnt[i] != 8'd0);
    end

endmodule

// File: rtl/usd_apu_bridge.sv
// APU front end for NUM_CH uSD channels: routes command words to per-channel
// command FIFOs by an in-word channel field, collects result words round-robin
// with a channel tag, and produces stretched per-channel soft resets.
// Optional build macro: USD_BRIDGE_STATS_EN enables the dropped-command counter.
//
// Handshakes: a command is taken in the cycle cmdWrEn is high (there is no
// back-pressure; a word aimed at a channel whose cmdRdy is low is dropped).
// A result is offered while resultValid is high and is consumed in the cycle
// resultRdEn is also high; resultData/resultCh stay stable until then.
module usd_apu_bridge
    import usd_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CMD_W      = CMD_W_DEF,
    parameter int RES_W      = RES_W_DEF,
    parameter int CH_LSB     = CH_LSB_DEF,
    parameter int RST_CYCLES = 15,
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    apuClk,
    input  logic                    sysRstN,
    input  logic [CMD_W-1:0]        cmdData,
    input  logic                    cmdWrEn,
    output logic [NUM_CH-1:0]       cmdRdy,
    output logic [CMD_W-1:0]        chCmdData,
    output logic [NUM_CH-1:0]       chCmdWrEn,
    input  logic [NUM_CH-1:0]       chCmdFull,
    input  logic [NUM_CH-1:0]       chInitComplete,
    input  logic [NUM_CH*RES_W-1:0] chResData,
    input  logic [NUM_CH-1:0]       chResEmpty,
    output logic [NUM_CH-1:0]       chResRdEn,
    output logic [RES_W-1:0]        resultData,
    output logic [CHW-1:0]          resultCh,
    output logic                    resultValid,
    input  logic                    resultRdEn,
    input  logic                    apuReset,
    input  logic [NUM_CH-1:0]       apuResetMask,
    output logic [NUM_CH-1:0]       chRst,
    output logic [7:0]              dropCnt,
    output logic [1:0]              dbgResState
);

    // ---------------- soft reset ----------------
    usd_rst_stretch #(
        .WIDTH      (NUM_CH),
        .RST_CYCLES (RST_CYCLES)
    ) uRstStretch (
        .apuClk       (apuClk),
        .sysRstN      (sysRstN),
        .apuReset     (apuReset),
        .apuResetMask (apuResetMask),
        .chRst        (chRst)
    );

    // ---------------- command path ----------------
    logic [CHW-1:0]    cmdCh;
    logic [NUM_CH-1:0] cmdHit;
    logic              cmdAccept;

    assign cmdRdy = ~chCmdFull & ~chRst & chInitComplete;
    assign cmdCh  = cmdData[CH_LSB +: CHW];

    // Decode the target channel; a channel number >= NUM_CH matches no bit and is dropped.
    always_comb begin
        cmdHit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmdHit[i] = cmdWrEn && (cmdCh == CHW'(i)) && cmdRdy[i];
        end
    end

    assign cmdAccept = |cmdHit;

    // Register the accepted word and pulse the one-hot FIFO write for one cycle.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            chCmdWrEn <= '0;
            chCmdData <= '0;
        end else begin
            chCmdWrEn <= cmdHit;
            if (cmdAccept) chCmdData <= cmdData;
        end
    end

`ifdef USD_BRIDGE_STATS_EN
    logic [7:0] dropCntQ;

    // Count rejected command words, saturating at 255.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            dropCntQ <= 8'd0;
        end else if (cmdWrEn && !cmdAccept && (dropCntQ != 8'hFF)) begin
            dropCntQ <= dropCntQ + 8'd1;
        end
    end

    assign dropCnt = dropCntQ;
`else
    assign dropCnt = 8'd0;
`endif

    // ---------------- result path ----------------
    resState_e         state;
    resState_e         stateNext;
    logic [NUM_CH-1:0] elig;
    logic [CHW-1:0]    ptr;
    logic [CHW-1:0]    selCh;
    logic [CHW-1:0]    pickCh;
    logic [CHW-1:0]    pickNextPtr;
    logic              pickFound;
    logic              doIssue;
    logic              doCapture;
    logic              doRelease;

    assign elig        = ~chResEmpty & chInitComplete & ~chRst;
    assign dbgResState = state;

    // Round-robin pick: first eligible channel at or after the pointer.
    always_comb begin
        int idx;
        idx       = 0;
        pickFound = 1'b0;
        pickCh    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!pickFound && elig[idx]) begin
                pickFound = 1'b1;
                pickCh    = CHW'(idx);
            end
        end
        pickNextPtr = ((int'(pickCh) + 1) >= NUM_CH) ? '0 : CHW'(int'(pickCh) + 1);
    end

    // Result FSM state register.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) state <= IDLE;
        else          state <= stateNext;
    end

    // Next state and datapath strobes; HOLD chains straight into the next read.
    always_comb begin
        stateNext = state;
        doIssue   = 1'b0;
        doCapture = 1'b0;
        doRelease = 1'b0;
        case (state)
            IDLE: begin
                if (pickFound) begin
                    doIssue   = 1'b1;
                    stateNext = FETCH;
                end
            end
            FETCH: stateNext = CAPT;
            CAPT: begin
                doCapture = 1'b1;
                stateNext = HOLD;
            end
            HOLD: begin
                if (resultRdEn) begin
                    doRelease = 1'b1;
                    if (pickFound) begin
                        doIssue   = 1'b1;
                        stateNext = FETCH;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read strobe, pointer, and held result; a word once read is always presented.
    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            chResRdEn   <= '0;
            ptr         <= '0;
            selCh       <= '0;
            resultData  <= '0;
            resultCh    <= '0;
            resultValid <= 1'b0;
        end else begin
            chResRdEn <= '0;
            if (doIssue) begin
                chResRdEn <= NUM_CH'(1) << pickCh;
                selCh     <= pickCh;
                ptr       <= pickNextPtr;
            end
            if (doCapture) begin
                resultData  <= chResData[int'(selCh)*RES_W +: RES_W];
                resultCh    <= selCh;
                resultValid <= 1'b1;
            end else if (doRelease) begin
                resultValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usd_apu_bridge.sv
// Directed bench for usd_apu_bridge with queue-based scoreboards for command
// writes, delivered results and soft-reset pulse lengths.
module tb_usd_apu_bridge;

    localparam int NUM_CH     = 2;
    localparam int CMD_W      = 72;
    localparam int RES_W      = 36;
    localparam int CHW        = 1;
`ifdef USD_BRIDGE_STATS_EN
    localparam int DROP_EXP   = 2;
`else
    localparam int DROP_EXP   = 0;
`endif

    logic                    apuClk;
    logic                    sysRstN;
    logic [CMD_W-1:0]        cmdData;
    logic                    cmdWrEn;
    logic [NUM_CH-1:0]       cmdRdy;
    logic [CMD_W-1:0]        chCmdData;
    logic [NUM_CH-1:0]       chCmdWrEn;
    logic [NUM_CH-1:0]       chCmdFull;
    logic [NUM_CH-1:0]       chInitComplete;
    logic [NUM_CH*RES_W-1:0] chResData;
    logic [NUM_CH-1:0]       chResEmpty;
    logic [NUM_CH-1:0]       chResRdEn;
    logic [RES_W-1:0]        resultData;
    logic [CHW-1:0]          resultCh;
    logic                    resultValid;
    logic                    resultRdEn;
    logic                    apuReset;
    logic [NUM_CH-1:0]       apuResetMask;
    logic [NUM_CH-1:0]       chRst;
    logic [7:0]              dropCnt;
    logic [1:0]              dbgResState;

    int compared   = 0;
    int mismatched = 0;

    logic [NUM_CH+CMD_W-1:0] cmdExpQ[$];
    logic [CHW+RES_W-1:0]    resExpQ[$];
    logic [7:0]              pulseExpQ[$];

    int resDelivered = 0;
    int rd1Total     = 0;
    int hi1Total     = 0;
    int pulseDone    = 0;
    int hiCnt        = 0;

    usd_apu_bridge dut (
        .apuClk         (apuClk),
        .sysRstN        (sysRstN),
        .cmdData        (cmdData),
        .cmdWrEn        (cmdWrEn),
        .cmdRdy         (cmdRdy),
        .chCmdData      (chCmdData),
        .chCmdWrEn      (chCmdWrEn),
        .chCmdFull      (chCmdFull),
        .chInitComplete (chInitComplete),
        .chResData      (chResData),
        .chResEmpty     (chResEmpty),
        .chResRdEn      (chResRdEn),
        .resultData     (resultData),
        .resultCh       (resultCh),
        .resultValid    (resultValid),
        .resultRdEn     (resultRdEn),
        .apuReset       (apuReset),
        .apuResetMask   (apuResetMask),
        .chRst          (chRst),
        .dropCnt        (dropCnt),
        .dbgResState    (dbgResState)
    );

    // ---------------- clock ----------------
    initial apuClk = 1'b0;
    always #5 apuClk = ~apuClk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- result FIFO models (standard read) ----------------
    logic [RES_W-1:0] mem0 [8];
    logic [RES_W-1:0] mem1 [8];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
    logic [RES_W-1:0] dout0 = '0, dout1 = '0;

    assign chResEmpty = {wp1 == rp1, wp0 == rp0};
    assign chResData  = {dout1, dout0};

    always @(posedge apuClk) begin
        if (chResRdEn[0]) begin
            dout0 <= mem0[rp0[2:0]];
            rp0   <= rp0 + 1;
        end
        if (chResRdEn[1]) begin
            dout1 <= mem1[rp1[2:0]];
            rp1   <= rp1 + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    // Command monitor: every FIFO write must match the next expected word.
    always @(negedge apuClk) begin : cmdMon
        logic [NUM_CH+CMD_W-1:0] e;
        if (sysRstN && chCmdWrEn != '0) begin
            if (cmdExpQ.size() == 0) begin
                failNow("cmd_unexpected_write");
            end else begin
                e = cmdExpQ.pop_front();
                check("cmd_write", 128'({chCmdWrEn, chCmdData}), 128'(e));
            end
        end
    end

    // Result monitor: compare each consumed result and track channel-1 reads.
    always @(negedge apuClk) begin : resMon
        logic [CHW+RES_W-1:0] e;
        if (sysRstN && chResRdEn[1]) rd1Total++;
        if (sysRstN && resultValid && resultRdEn) begin
            resDelivered++;
            if (resExpQ.size() == 0) begin
                failNow("res_unexpected_word");
            end else begin
                e = resExpQ.pop_front();
                check("res_word", 128'({resultCh, resultData}), 128'(e));
            end
        end
    end

    // Pulse monitor: measure each chRst[0] pulse length in cycles.
    always @(negedge apuClk) begin : pulseMon
        logic [7:0] e;
        if (!sysRstN) begin
            hiCnt = 0;
        end else begin
            if (chRst[1]) hi1Total++;
            if (chRst[0]) begin
                hiCnt++;
            end else if (hiCnt != 0) begin
                if (pulseExpQ.size() == 0) begin
                    failNow("rst_unexpected_pulse");
                end else begin
                    e = pulseExpQ.pop_front();
                    check("rst_pulse_len", 128'(hiCnt), 128'(e));
                end
                hiCnt = 0;
                pulseDone++;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic sendCmd(input logic [1:0] chField, input logic [55:0] payload,
                           input logic [NUM_CH-1:0] expEn);
        logic [CMD_W-1:0] word;
        word = {14'h1A5, chField, payload};
        if (expEn != '0) cmdExpQ.push_back({expEn, word});
        cmdWrEn = 1'b1;
        cmdData = word;
        @(posedge apuClk);
        #1;
        cmdWrEn = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge apuClk);
        #1;
    endtask

    task automatic waitResDrained(input string name);
        int n;
        n = 0;
        while (resExpQ.size() != 0 && n < 200) begin
            @(posedge apuClk);
            n++;
        end
        #1;
        check(name, 128'(resExpQ.size()), 128'(0));
    endtask

    task automatic waitPulses(input int target);
        int n;
        n = 0;
        while (pulseDone < target && n < 200) begin
            @(posedge apuClk);
            n++;
        end
        #1;
        check("rst_pulse_seen", 128'(pulseDone), 128'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int startCnt;
        sysRstN        = 1'b0;
        cmdData        = '0;
        cmdWrEn        = 1'b0;
        chCmdFull      = '0;
        chInitComplete = 2'b11;
        resultRdEn     = 1'b0;
        apuReset       = 1'b0;
        apuResetMask   = '0;

        // Reset state
        cycles(2);
        check("rst_chCmdWrEn",   128'(chCmdWrEn),   128'(0));
        check("rst_chResRdEn",   128'(chResRdEn),   128'(0));
        check("rst_resultValid", 128'(resultValid), 128'(0));
        check("rst_resultData",  128'(resultData),  128'(0));
        check("rst_chRst",       128'(chRst),       128'(0));
        check("rst_dropCnt",     128'(dropCnt),     128'(0));
        check("rst_chCmdData",   128'(chCmdData),   128'(0));
        check("rst_fsm",         128'(dbgResState), 128'(0));
        sysRstN = 1'b1;
        cycles(2);

        // Command routing, including back-to-back words
        check("cmdRdy_all", 128'(cmdRdy), 128'(2'b11));
        sendCmd(2'b01, 56'h00_1111_2222_3333, 2'b10);
        sendCmd(2'b00, 56'h44_5555_6666_7777, 2'b01);
        sendCmd(2'b01, 56'h88_9999_AAAA_BBBB, 2'b10);
        cycles(2);
        check("cmd_q_drained", 128'(cmdExpQ.size()), 128'(0));
        check("dropCnt_none",  128'(dropCnt),        128'(0));

        // Drops: full FIFO on ch0, then field 3 (decodes to ch1) with ch1 not initialised
        chCmdFull = 2'b01;
        #1;
        check("cmdRdy_full0", 128'(cmdRdy), 128'(2'b10));
        sendCmd(2'b00, 56'h00_DEAD_0000_0001, 2'b00);
        chCmdFull      = 2'b00;
        chInitComplete = 2'b01;
        #1;
        check("cmdRdy_noinit1", 128'(cmdRdy), 128'(2'b01));
        sendCmd(2'b11, 56'h00_DEAD_0000_0002, 2'b00);
        cycles(2);
        check("dropCnt_two", 128'(dropCnt), 128'(DROP_EXP));

        // Uninitialised channel with data is never read
        mem1[0] = 36'h1_0000_00C1;
        wp1     = 1;
        cycles(20);
        check("ch1_noinit_no_read", 128'(rd1Total),    128'(0));
        check("ch1_noinit_no_res",  128'(resultValid), 128'(0));

        // Enabling it releases the pending word
        resultRdEn = 1'b1;
        resExpQ.push_back({1'b1, 36'h1_0000_00C1});
        chInitComplete = 2'b11;
        waitResDrained("res_ch1_after_init");

        // Round-robin over two words per channel with resultRdEn held high
        startCnt = resDelivered;
        mem0[0] = 36'h0_A000_0001;
        mem0[1] = 36'h0_A000_0002;
        mem1[1] = 36'h1_B000_0001;
        mem1[2] = 36'h1_B000_0002;
        resExpQ.push_back({1'b0, 36'h0_A000_0001});
        resExpQ.push_back({1'b1, 36'h1_B000_0001});
        resExpQ.push_back({1'b0, 36'h0_A000_0002});
        resExpQ.push_back({1'b1, 36'h1_B000_0002});
        wp0 = 2;
        wp1 = 3;
        waitResDrained("res_rr_drained");
        check("res_rr_count", 128'(resDelivered - startCnt), 128'(4));

        // Soft reset pulse on ch0 only: 15 cycles
        apuResetMask = 2'b01;
        pulseExpQ.push_back(8'd15);
        apuReset = 1'b1;
        cycles(3);
        apuReset = 1'b0;
        waitPulses(1);

        // Second edge lands at cycle 10 of the pulse: 25 cycles total
        pulseExpQ.push_back(8'd25);
        apuReset = 1'b1;
        cycles(3);
        apuReset = 1'b0;
        n = 0;
        while (!chRst[0] && n < 20) begin
            @(negedge apuClk);
            n++;
        end
        check("rst_pulse2_started", 128'(chRst[0]), 128'(1));
        repeat (7) @(posedge apuClk);
        #1;
        apuReset = 1'b1;
        cycles(3);
        apuReset = 1'b0;
        waitPulses(2);
        check("rst_ch1_untouched", 128'(hi1Total), 128'(0));

        // System reset while a result is held and a soft reset is running
        resultRdEn = 1'b0;
        mem0[2]    = 36'h0_C000_0001;
        wp0        = 3;
        n = 0;
        while (!resultValid && n < 20) begin
            @(posedge apuClk);
            n++;
        end
        #1;
        check("hold_valid",   128'(resultValid), 128'(1));
        check("hold_state",   128'(dbgResState), 128'(3));
        check("hold_data",    128'(resultData),  128'(36'h0_C000_0001));
        apuResetMask = 2'b10;
        apuReset     = 1'b1;
        cycles(4);
        check("ch1_soft_rst", 128'(chRst), 128'(2'b10));
        #2;
        sysRstN  = 1'b0;
        apuReset = 1'b0;
        #1;
        check("sysrst_valid",   128'(resultValid), 128'(0));
        check("sysrst_chRst",   128'(chRst),       128'(0));
        check("sysrst_dropCnt", 128'(dropCnt),     128'(0));
        check("sysrst_fsm",     128'(dbgResState), 128'(0));
        check("sysrst_data",    128'(resultData),  128'(0));
        @(posedge apuClk);
        #1;
        sysRstN = 1'b1;
        cycles(2);

        // Pointer is back at 0: channel 0 is served first again
        resultRdEn = 1'b1;
        mem0[3] = 36'h0_D000_0001;
        mem1[3] = 36'h1_D000_0002;
        resExpQ.push_back({1'b0, 36'h0_D000_0001});
        resExpQ.push_back({1'b1, 36'h1_D000_0002});
        wp0 = 4;
        wp1 = 4;
        waitResDrained("res_after_sysrst");

        cycles(2);
        check("cmd_q_final",   128'(cmdExpQ.size()),   128'(0));
        check("pulse_q_final", 128'(pulseExpQ.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
